// File: rtl/full_adder_pkg.sv
// Shared constants and types for the full adder and its input-pattern coverage.
package full_adder_pkg;

    localparam int NUM_PATTERNS = 8;

    typedef logic [NUM_PATTERNS-1:0] cov_mask_t;

endpackage

// File: rtl/full_adder_half_adder.sv
// Half adder: s = a ^ b, c = a & b.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// Full adder built from two half adders, with registered outputs and
// sticky coverage of which {A,B,cin} patterns have been sampled.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int COV_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       cin,
    output logic       cout,
    output logic       sum,
    output logic       prop,
    output logic       gen,
    output logic       sum_q,
    output logic       cout_q,
    output logic [7:0] cov_mask,
    output logic       cov_full
);

    logic carry2;

    half_adder u_ha0 (
        .a (A),
        .b (B),
        .s (prop),
        .c (gen)
    );

    half_adder u_ha1 (
        .a (prop),
        .b (cin),
        .s (sum),
        .c (carry2)
    );

    assign cout = gen | carry2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum;
            cout_q <= cout;
        end
    end

    generate
        if (COV_EN != 0) begin : g_cov
            cov_mask_t  mask_r;
            logic [2:0] pattern;

            assign pattern = {A, B, cin};

            // Sticky: OR in the bit for the pattern present at this edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    mask_r <= '0;
                end else begin
                    mask_r <= mask_r | (cov_mask_t'(1) << pattern);
                end
            end

            assign cov_mask = mask_r;
            assign cov_full = &mask_r;
        end else begin : g_no_cov
            assign cov_mask = '0;
            assign cov_full = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// Directed plus randomized bench for full_adder, with an arithmetic reference model.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       A, B, cin;

    logic       cout, sum, prop, gen, sum_q, cout_q, cov_full;
    logic [7:0] cov_mask;
    logic       cout_n, sum_n, prop_n, gen_n, sum_q_n, cout_q_n, cov_full_n;
    logic [7:0] cov_mask_n;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [7:0] exp_mask = 8'h00;
    logic [1:0] exp_q    = 2'b00;
    bit         primed   = 1'b0;

    always #5 clk = ~clk;

    full_adder #(.COV_EN(1)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin),
        .cout(cout), .sum(sum), .prop(prop), .gen(gen),
        .sum_q(sum_q), .cout_q(cout_q), .cov_mask(cov_mask), .cov_full(cov_full)
    );

    full_adder #(.COV_EN(0)) dut_nocov (
        .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin),
        .cout(cout_n), .sum(sum_n), .prop(prop_n), .gen(gen_n),
        .sum_q(sum_q_n), .cout_q(cout_q_n), .cov_mask(cov_mask_n), .cov_full(cov_full_n)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag);
        int s;
        int ab;
        s  = int'(A) + int'(B) + int'(cin);
        ab = int'(A) + int'(B);
        check({tag, "_coutsum"},   {6'b0, cout, sum},     8'(s));
        check({tag, "_prop"},      {7'b0, prop},          (ab == 1) ? 8'd1 : 8'd0);
        check({tag, "_gen"},       {7'b0, gen},           (ab == 2) ? 8'd1 : 8'd0);
        check({tag, "_nc_coutsum"}, {6'b0, cout_n, sum_n}, 8'(s));
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_q"},        {6'b0, cout_q, sum_q}, {6'b0, exp_q});
        check({tag, "_mask"},     cov_mask,              exp_mask);
        check({tag, "_full"},     {7'b0, cov_full},      (exp_mask == 8'hFF) ? 8'd1 : 8'd0);
        check({tag, "_nc_q"},     {6'b0, cout_q_n, sum_q_n}, {6'b0, exp_q});
        check({tag, "_nc_mask"},  cov_mask_n,            8'h00);
        check({tag, "_nc_full"},  {7'b0, cov_full_n},    8'h00);
    endtask

    // Drive inputs away from the edge, take one rising edge, update the model.
    task automatic step(input string tag, input logic a, input logic b, input logic c, input logic r);
        int idx;
        A = a; B = b; cin = c; rst = r;
        #1;
        check_comb({tag, "_pre"});
        if (primed) check_regs({tag, "_pre"});
        @(posedge clk);
        if (r) begin
            exp_q    = 2'b00;
            exp_mask = 8'h00;
        end else begin
            exp_q         = 2'(int'(a) + int'(b) + int'(c));
            idx           = int'(a) * 4 + int'(b) * 2 + int'(c);
            exp_mask[idx] = 1'b1;
        end
        primed = 1'b1;
        #1;
        check_regs({tag, "_post"});
    endtask

    initial begin
        logic [2:0] p;
        logic [2:0] coutsum_tbl [8];
        coutsum_tbl = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3};

        rst = 1'b1; A = 1'b0; B = 1'b0; cin = 1'b0;
        step("rst0", 1'b0, 1'b0, 1'b0, 1'b1);
        step("rst1", 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_mask", cov_mask, 8'h00);

        // Exhaustive combinational sweep while held in reset.
        for (int k = 0; k < 8; k++) begin
            p = 3'(k);
            {A, B, cin} = p;
            #1;
            check("exh_table", {6'b0, cout, sum}, {5'b0, coutsum_tbl[k]});
            check_comb("exh");
            #9;
        end
        check("exh_regs_held", {6'b0, cout_q, sum_q}, 8'h00);

        A = 1'b1; B = 1'b0; cin = 1'b0; #1;
        check("pg10_prop", {7'b0, prop}, 8'd1);
        check("pg10_gen",  {7'b0, gen},  8'd0);
        A = 1'b1; B = 1'b1; #1;
        check("pg11_prop", {7'b0, prop}, 8'd0);
        check("pg11_gen",  {7'b0, gen},  8'd1);
        @(posedge clk); #1;

        step("reg111", 1'b1, 1'b1, 1'b1, 1'b0);
        check("reg111_q", {6'b0, cout_q, sum_q}, 8'd3);

        step("covrst", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            p = 3'(k);
            step("cov", p[2], p[1], p[0], 1'b0);
        end
        check("cov_7f",      cov_mask,          8'h7F);
        check("cov_7f_full", {7'b0, cov_full},  8'd0);
        step("cov7", 1'b1, 1'b1, 1'b1, 1'b0);
        check("cov_ff",      cov_mask,          8'hFF);
        check("cov_ff_full", {7'b0, cov_full},  8'd1);
        step("cov_rep", 1'b0, 1'b1, 1'b0, 1'b0);

        // Mid-run reset discards history; capture resumes on the next edge.
        step("mid_rst_a", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            p = 3'($urandom_range(0, 7));
            step("mid", p[2], p[1], p[0], 1'b0);
        end
        step("mid_rst", 1'b1, 1'b0, 1'b1, 1'b1);
        check("mid_rst_mask", cov_mask, 8'h00);
        check("mid_rst_q",    {6'b0, cout_q, sum_q}, 8'h00);
        for (int k = 0; k < 4; k++) begin
            p = 3'($urandom_range(0, 7));
            {A, B, cin} = p;
            #1;
            check_comb("in_rst");
        end
        step("resume", 1'b0, 1'b1, 1'b1, 1'b0);
        check("resume_mask", cov_mask, 8'h08);

        // Random run with mid-cycle glitches and occasional resets.
        for (int k = 0; k < 80; k++) begin
            p = 3'($urandom_range(0, 7));
            {A, B, cin} = p;
            #2;
            p = 3'($urandom_range(0, 7));
            step("rnd", p[2], p[1], p[0], ($urandom_range(0, 11) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
